// File: rtl/mt9v034_timing_gen.sv
// Synthetic MT9V034-style frame source: vsync/href/8-bit data on the pixel clock,
// free-running frames while enabled, selectable test patterns latched per frame.
module mt9v034_timing_gen #(
  parameter int unsigned H_ACTIVE = 752,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 200,
  parameter int unsigned V_FRONT  = 4000,
  parameter int unsigned V_SETUP  = 200,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk_25M,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern_sel,
  input  logic [7:0]  i_const_value,
  output logic        o_image_sensor_vsync,
  output logic        o_image_sensor_href,
  output logic [7:0]  o_image_sensor_data,
  output logic [15:0] o_frame_cnt,
  output logic        o_frame_done,
  output logic        o_busy
);

  localparam int unsigned FC_W = 16;
  localparam logic [CNT_W-1:0] FRONT_LAST = CNT_W'(V_FRONT - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(V_SETUP - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] B_LAST     = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRONT,
    S_SETUP,
    S_ACTIVE,
    S_BLANK
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  y_q, y_d;
  logic [1:0]        pat_q, pat_d;
  logic [7:0]        cv_q, cv_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d;

  // Pixel value for active coordinate (x,y) in frame f, all mod 256.
  function automatic logic [7:0] pixel(input logic [1:0] sel, input logic [7:0] x,
                                       input logic [7:0] y, input logic [7:0] f,
                                       input logic [7:0] cv);
    case (sel)
      2'd0:    return x + y + f;
      2'd1:    return x;
      2'd2:    return (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      default: return cv;
    endcase
  endfunction

  always_ff @(posedge clk_25M or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      y_q          <= '0;
      pat_q        <= '0;
      cv_q         <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      y_q          <= y_d;
      pat_q        <= pat_d;
      cv_q         <= cv_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
    end
  end

  // Phase sequencing; outputs are derived from the next state so they register with it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    y_d          = y_q;
    pat_d        = pat_q;
    cv_d         = cv_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        y_d   = '0;
        if (i_enable) state_d = S_FRONT;
      end
      S_FRONT: begin
        if (cnt_q == FRONT_LAST) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          pat_d   = i_pattern_sel;
          cv_d    = i_const_value;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          y_d     = '0;
        end
      end
      S_ACTIVE: begin
        if (cnt_q == H_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
        end
      end
      S_BLANK: begin
        if (cnt_q == B_LAST) begin
          cnt_d = '0;
          if (y_q == V_LAST) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + FC_W'(1);
            state_d      = i_enable ? S_FRONT : S_IDLE;
          end else begin
            y_d     = y_q + CNT_W'(1);
            state_d = S_ACTIVE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    vsync_d = (state_d == S_SETUP) || (state_d == S_ACTIVE) || (state_d == S_BLANK);
    href_d  = (state_d == S_ACTIVE);
    busy_d  = (state_d != S_IDLE);
    data_d  = href_d ? pixel(pat_d, cnt_d[7:0], y_d[7:0], frame_cnt_q[7:0], cv_d) : 8'h00;
  end

  assign o_image_sensor_vsync = vsync_q;
  assign o_image_sensor_href  = href_q;
  assign o_image_sensor_data  = data_q;
  assign o_frame_cnt          = frame_cnt_q;
  assign o_frame_done         = frame_done_q;
  assign o_busy               = busy_q;

endmodule

// File: tb/tb_mt9v034_timing_gen.sv
// Bench for mt9v034_timing_gen: default-size and small-size instances checked every
// cycle against a frame-position model, plus hand-computed pixel and timing values.
module tb_mt9v034_timing_gen;

  localparam int HA [2] = '{752, 8};
  localparam int HB [2] = '{200, 2};
  localparam int VA [2] = '{480, 4};
  localparam int VF [2] = '{4000, 3};
  localparam int VS [2] = '{200, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, en, vs, hr, done, busy;
  logic [1:0][1:0]  pat;
  logic [1:0][7:0]  cv, dat;
  logic [1:0][15:0] fc;

  mt9v034_timing_gen u_def (
    .clk_25M(clk), .i_rst_n(rst[0]), .i_enable(en[0]), .i_pattern_sel(pat[0]),
    .i_const_value(cv[0]), .o_image_sensor_vsync(vs[0]), .o_image_sensor_href(hr[0]),
    .o_image_sensor_data(dat[0]), .o_frame_cnt(fc[0]), .o_frame_done(done[0]),
    .o_busy(busy[0])
  );

  mt9v034_timing_gen #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(2), .V_FRONT(3), .V_SETUP(2), .CNT_W(16)
  ) u_small (
    .clk_25M(clk), .i_rst_n(rst[1]), .i_enable(en[1]), .i_pattern_sel(pat[1]),
    .i_const_value(cv[1]), .o_image_sensor_vsync(vs[1]), .o_image_sensor_href(hr[1]),
    .o_image_sensor_data(dat[1]), .o_frame_cnt(fc[1]), .o_frame_done(done[1]),
    .o_busy(busy[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int period(input int i);
    return VF[i] + VS[i] + VA[i] * (HA[i] + HB[i]);
  endfunction

  // Model: position inside the frame cycle, frame count, per-frame latched pattern.
  bit         m_busy [2];
  int         m_p    [2];
  logic [15:0] m_cnt [2];
  bit         m_done [2];
  logic [1:0] m_pat  [2];
  logic [7:0] m_cv   [2];
  int         m_f    [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_busy[i] = 1'b0; m_p[i] = 0; m_cnt[i] = '0; m_done[i] = 1'b0;
        m_pat[i] = '0; m_cv[i] = '0; m_f[i] = 0;
      end else if (!m_busy[i]) begin
        m_done[i] = 1'b0;
        if (en[i]) begin
          m_busy[i] = 1'b1;
          m_p[i] = 0;
        end
      end else if (m_p[i] == period(i) - 1) begin
        m_done[i] = 1'b1;
        m_cnt[i]  = m_cnt[i] + 16'd1;
        m_p[i]    = 0;
        m_busy[i] = en[i];
      end else begin
        m_done[i] = 1'b0;
        m_p[i]++;
        if (m_p[i] == VF[i]) begin
          m_pat[i] = pat[i];
          m_cv[i]  = cv[i];
          m_f[i]   = int'(m_cnt[i]);
        end
      end
    end
  end

  function automatic void model_out(input int i, output logic e_vs, output logic e_hr,
                                    output logic [7:0] e_d);
    int q, r, x, y;
    e_vs = 1'b0; e_hr = 1'b0; e_d = 8'h00;
    if (m_busy[i] && m_p[i] >= VF[i]) begin
      e_vs = 1'b1;
      q = m_p[i] - VF[i];
      if (q >= VS[i]) begin
        r = q - VS[i];
        y = r / (HA[i] + HB[i]);
        x = r % (HA[i] + HB[i]);
        if (x < HA[i]) begin
          e_hr = 1'b1;
          case (m_pat[i])
            2'd0:    e_d = 8'((x + y + m_f[i]) % 256);
            2'd1:    e_d = 8'(x % 256);
            2'd2:    e_d = (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
            default: e_d = m_cv[i];
          endcase
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic e_vs, e_hr;
      logic [7:0] e_d;
      if (!rst[i]) begin
        model_out(i, e_vs, e_hr, e_d);
        chk(i != 0 ? "s_vsync" : "d_vsync", 32'(vs[i]), 32'(e_vs));
        chk(i != 0 ? "s_href" : "d_href", 32'(hr[i]), 32'(e_hr));
        chk(i != 0 ? "s_data" : "d_data", 32'(dat[i]), 32'(e_d));
        chk(i != 0 ? "s_busy" : "d_busy", 32'(busy[i]), 32'(m_busy[i]));
        chk(i != 0 ? "s_done" : "d_done", 32'(done[i]), 32'(m_done[i]));
        chk(i != 0 ? "s_fcnt" : "d_fcnt", 32'(fc[i]), 32'(m_cnt[i]));
      end
    end
  end

  // Observer: pixel coordinates and frame-done pulses seen on the outputs.
  int ox [2], oy [2], done_seen [2];
  bit pv [2], ph [2];
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        ox[i] = 0; oy[i] = -1; done_seen[i] = 0; pv[i] = 1'b0; ph[i] = 1'b0;
      end else begin
        if (vs[i] && !pv[i]) oy[i] = -1;
        if (hr[i]) begin
          if (!ph[i]) begin
            oy[i]++;
            ox[i] = 0;
          end else begin
            ox[i]++;
          end
        end
        if (done[i]) done_seen[i]++;
        pv[i] = vs[i];
        ph[i] = hr[i];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout at %0t", nm, $time);
  endtask

  task automatic wait_pix(input int i, input int x, input int y, input int budget,
                          input string nm);
    int n = 0;
    while (!(hr[i] && ox[i] == x && oy[i] == y) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) timeout(nm);
  endtask

  task automatic wait_fc(input int i, input int val, input int budget, input string nm);
    int n = 0;
    while (fc[i] != 16'(val) && n < budget) begin
      step();
      n++;
    end
    chk(nm, 32'(fc[i]), 32'(val));
  endtask

  task automatic wait_idle(input int i, input int budget, input string nm);
    int n = 0;
    while (busy[i] && n < budget) begin
      step();
      n++;
    end
    chk(nm, 32'(busy[i]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 2'b11; en = 2'b00; pat = '0; cv = '0;
    #2;

    // Reset held, enable toggling: everything stays at zero.
    for (int k = 0; k < 4; k++) begin
      en = (k % 2 == 1) ? 2'b11 : 2'b00;
      step();
      for (int i = 0; i < 2; i++) begin
        chk("rst_vsync", 32'(vs[i]), 32'd0);
        chk("rst_href", 32'(hr[i]), 32'd0);
        chk("rst_data", 32'(dat[i]), 32'd0);
        chk("rst_busy", 32'(busy[i]), 32'd0);
        chk("rst_done", 32'(done[i]), 32'd0);
        chk("rst_fcnt", 32'(fc[i]), 32'd0);
      end
    end
    en = 2'b00;
    rst = 2'b00;
    step();

    // Small instance, diagonal ramp over two frames.
    pat[1] = 2'd0;
    en[1] = 1'b1;
    wait_fc(1, 1, 200, "s_fcnt_first");
    chk("s_done_at_fall", 32'(done[1]), 32'd1);
    chk("s_done_count1", 32'(done_seen[1]), 32'd1);
    wait_pix(1, 0, 0, 100, "s_wait_0_0");
    chk("s_diag_0_0", 32'(dat[1]), 32'h01);
    wait_pix(1, 3, 2, 100, "s_wait_3_2");
    chk("s_diag_3_2", 32'(dat[1]), 32'h06);
    wait_fc(1, 2, 100, "s_fcnt_second");
    chk("s_done_count2", 32'(done_seen[1]), 32'd2);

    // Fresh start, enable dropped during line 1: the frame still completes.
    rst[1] = 1'b1;
    step();
    chk("s_rst_fcnt", 32'(fc[1]), 32'd0);
    rst[1] = 1'b0;
    pat[1] = 2'd3;
    cv[1] = 8'h5A;
    en[1] = 1'b1;
    wait_pix(1, 2, 1, 100, "s_wait_2_1");
    chk("s_const", 32'(dat[1]), 32'h5A);
    en[1] = 1'b0;
    pat[1] = 2'd1;
    wait_idle(1, 100, "s_idle_after_drop");
    chk("s_drop_fcnt", 32'(fc[1]), 32'd1);
    chk("s_drop_done", 32'(done_seen[1]), 32'd1);
    chk("s_drop_lines", 32'(oy[1]), 32'd3);
    repeat (10) step();
    chk("s_stay_idle", 32'(busy[1]), 32'd0);
    chk("s_stay_vsync", 32'(vs[1]), 32'd0);

    // Default instance, horizontal ramp: frame timing and pixel values.
    pat[0] = 2'd1;
    en[0] = 1'b1;
    cnt = 0;
    step();
    while (!vs[0] && cnt < 5000) begin
      cnt++;
      step();
    end
    chk("d_front_len", 32'(cnt), 32'd4000);
    cnt = 0;
    while (!hr[0] && cnt < 300) begin
      cnt++;
      step();
    end
    chk("d_setup_len", 32'(cnt), 32'd200);
    for (int ln = 0; ln < 2; ln++) begin
      cnt = 0;
      while (hr[0] && cnt < 1000) begin
        if (ln == 0 && cnt == 0)   chk("d_hramp_0", 32'(dat[0]), 32'h00);
        if (ln == 0 && cnt == 255) chk("d_hramp_255", 32'(dat[0]), 32'hFF);
        if (ln == 0 && cnt == 751) chk("d_hramp_751", 32'(dat[0]), 32'hEF);
        cnt++;
        step();
      end
      chk("d_href_len", 32'(cnt), 32'd752);
      cnt = 0;
      while (!hr[0] && cnt < 300) begin
        cnt++;
        step();
      end
      chk("d_gap_len", 32'(cnt), 32'd200);
    end

    // Reset mid-line takes effect within the cycle.
    wait_pix(0, 100, 2, 1000, "d_wait_100_2");
    rst[0] = 1'b1;
    #1;
    chk("d_async_href", 32'(hr[0]), 32'd0);
    chk("d_async_vsync", 32'(vs[0]), 32'd0);
    chk("d_async_data", 32'(dat[0]), 32'd0);
    chk("d_async_busy", 32'(busy[0]), 32'd0);
    step();
    rst[0] = 1'b0;
    pat[0] = 2'd2;
    step();
    chk("d_restart_busy", 32'(busy[0]), 32'd1);
    chk("d_restart_vsync", 32'(vs[0]), 32'd0);
    chk("d_restart_fcnt", 32'(fc[0]), 32'd0);

    // Checkerboard; a mid-frame pattern change must not take effect.
    wait_pix(0, 0, 0, 5000, "d_wait_0_0");
    chk("d_chk_0_0", 32'(dat[0]), 32'h00);
    pat[0] = 2'd0;
    wait_pix(0, 8, 0, 100, "d_wait_8_0");
    chk("d_chk_8_0", 32'(dat[0]), 32'hFF);
    wait_pix(0, 16, 0, 100, "d_wait_16_0");
    chk("d_chk_16_0", 32'(dat[0]), 32'h00);
    wait_pix(0, 0, 8, 10000, "d_wait_0_8");
    chk("d_chk_0_8", 32'(dat[0]), 32'hFF);
    wait_pix(0, 8, 8, 100, "d_wait_8_8");
    chk("d_chk_8_8", 32'(dat[0]), 32'h00);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
